// File: rtl/mips_regfile_mp_if.sv
// Bus between the issue/writeback side (master) and the multi-port register file (slave).
interface mips_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] raddr;
    logic [NREAD*DATA_W-1:0] rdata;
    logic [NREAD-1:0]        rpend;
    logic [1:0]              we;
    logic [2*ADDR_W-1:0]     waddr;
    logic [2*DATA_W-1:0]     wdata;
    logic                    iss_valid;
    logic [ADDR_W-1:0]       iss_addr;
    logic [ADDR_W:0]         npend;

    modport master (
        output raddr, we, waddr, wdata, iss_valid, iss_addr,
        input  rdata, rpend, npend
    );

    modport slave (
        input  raddr, we, waddr, wdata, iss_valid, iss_addr,
        output rdata, rpend, npend
    );
endinterface

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file: NREAD combinational read ports with
// write-to-read bypass, two prioritised write lanes, optional hardwired r0
// and a per-register pending scoreboard with a registered pending count.
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input logic                clock,
    input logic                reset_n,
    mips_regfile_mp_if.slave   bus
);
    // With a hardwired r0 the register loops simply start at 1, so r0 is
    // never written, never pending and every read of it falls through to 0.
    localparam int FIRST = (ZERO_REG != 0) ? 1 : 0;

    logic [DATA_W-1:0]     regs_q [DEPTH];
    logic [DATA_W-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [ADDR_W:0]       npend_q, npend_d;
    logic [ADDR_W-1:0]     wa0, wa1;
    logic [DATA_W-1:0]     wd0, wd1;
    logic [NREAD*DATA_W-1:0] rdata_c;
    logic [NREAD-1:0]      rpend_c;

    assign wa0 = bus.waddr[0 +: ADDR_W];
    assign wa1 = bus.waddr[ADDR_W +: ADDR_W];
    assign wd0 = bus.wdata[0 +: DATA_W];
    assign wd1 = bus.wdata[DATA_W +: DATA_W];

    // Next register/scoreboard state: lane 1 applied after lane 0 so it wins
    // collisions; issue applied last so a new producer supersedes a retire.
    always_comb begin
        regs_d  = regs_q;
        pend_d  = pend_q;
        npend_d = '0;
        for (int r = FIRST; r < DEPTH; r++) begin
            if (bus.we[0] && wa0 == ADDR_W'(r)) begin
                regs_d[r] = wd0;
                pend_d[r] = 1'b0;
            end
            if (bus.we[1] && wa1 == ADDR_W'(r)) begin
                regs_d[r] = wd1;
                pend_d[r] = 1'b0;
            end
            if (bus.iss_valid && bus.iss_addr == ADDR_W'(r)) begin
                pend_d[r] = 1'b1;
            end
        end
        for (int r = 0; r < DEPTH; r++) begin
            npend_d = npend_d + (ADDR_W+1)'(pend_d[r]);
        end
    end

    // State registers; reset clears storage and scoreboard immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
            pend_q  <= '0;
            npend_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pend_q  <= pend_d;
            npend_q <= npend_d;
        end
    end

    // Combinational read ports with bypass; an in-flight write makes the
    // value valid, so it also masks the pending flag. Out-of-range and
    // hardwired-zero addresses never match and read 0. Outputs are forced
    // low while reset is held so bypassed write data cannot leak through.
    always_comb begin
        rdata_c = '0;
        rpend_c = '0;
        for (int k = 0; k < NREAD; k++) begin
            for (int r = FIRST; r < DEPTH; r++) begin
                if (bus.raddr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    rdata_c[k*DATA_W +: DATA_W] = regs_q[r];
                    rpend_c[k]                  = pend_q[r];
                    if (bus.we[0] && wa0 == ADDR_W'(r)) begin
                        rdata_c[k*DATA_W +: DATA_W] = wd0;
                        rpend_c[k]                  = 1'b0;
                    end
                    if (bus.we[1] && wa1 == ADDR_W'(r)) begin
                        rdata_c[k*DATA_W +: DATA_W] = wd1;
                        rpend_c[k]                  = 1'b0;
                    end
                end
            end
        end
        if (!reset_n) begin
            rdata_c = '0;
            rpend_c = '0;
        end
    end

    assign bus.rdata = rdata_c;
    assign bus.rpend = rpend_c;
    assign bus.npend = npend_q;
endmodule
